// File: rtl/fifo_rd_stream.sv
// Read-side streamer: pulls pixels from an async FIFO into a 2-entry skid buffer
// and presents them as a valid/ready stream with line/frame position flags.
`timescale 1ns/1ps
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_sol,
  output logic             out_eol,
  output logic             out_sof,
  output logic             out_eof,
  output logic             frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             frame_done_q;
  logic [DSIZE-1:0] skid_q [2];
  logic [DSIZE-1:0] skid_d [2];

  logic             pop;
  logic [2:0]       pending_words;
  logic [1:0]       tail_idx;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;

  // Words already owed to the skid buffer after this cycle's pop; a new read
  // is only issued if its data is guaranteed a free slot on arrival.
  assign pending_words = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rinc          = rrst_n & en & ~rempty & (pending_words < 3'd2);

  assign out_data   = out_valid ? skid_q[0] : '0;
  assign out_sol    = (x_q == '0);
  assign out_eol    = (x_q == X_LAST);
  assign out_sof    = (x_q == '0) && (y_q == '0);
  assign out_eof    = (x_q == X_LAST) && (y_q == Y_LAST);
  assign frame_done = frame_done_q;

  // Slot the arriving word lands in, after any head shift caused by pop.
  assign tail_idx = occ_q - {1'b0, pop};

  always_comb begin
    skid_d[0] = skid_q[0];
    skid_d[1] = skid_q[1];
    if (pop) begin
      skid_d[0] = skid_q[1];
    end
    if (inflight_q) begin
      if (tail_idx == 2'd0) begin
        skid_d[0] = rdata;
      end else begin
        skid_d[1] = rdata;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pop) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= rinc;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= pop & out_eof;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge rclk) begin
    skid_q[0] <= skid_d[0];
    skid_q[1] <= skid_d[1];
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT,
// a monitor checks every accepted pixel against its position in the frame.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int FRAME = IMG_W * IMG_H;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             en = 1'b0;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             out_ready = 1'b0;
  logic             rinc, out_valid, out_sol, out_eol, out_sof, out_eof, frame_done;
  logic [DSIZE-1:0] out_data;

  fifo_rd_stream #(.DSIZE(DSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done)
  );

  always #5 rclk = ~rclk;

  int n_chk = 0;
  int n_fail = 0;
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int rd_tot = 0, acc_tot = 0, disc_tot = 0, acc_cnt = 0, reset_gen = 0;
  logic rinc_s, s_valid, s_acc, s_fd;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DSIZE-1:0] d);
    fifo_q.push_back(d);
    rempty = 1'b0;
  endtask

  // One clock cycle; called at a falling edge with inputs already driven.
  task automatic step();
    #3;
    rinc_s  = rinc;
    s_valid = out_valid;
    s_acc   = out_valid & out_ready;
    s_fd    = frame_done;
    if (rempty) chk("rinc_while_empty", rinc_s, 0);
    @(posedge rclk);
    #1;
    if (rinc_s && fifo_q.size() != 0) begin
      rdata = fifo_q.pop_front();
      exp_q.push_back(rdata);
      rd_tot++;
      chk("outstanding_le_2", (rd_tot - acc_tot - disc_tot) <= 2, 1);
    end else begin
      rdata = DSIZE'($urandom);
    end
    rempty = (fifo_q.size() == 0);
    @(negedge rclk);
  endtask

  task automatic drain();
    int n;
    en = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    chk("drain_within_budget", n < 200, 1);
  endtask

  // Monitor: compares accepted pixels and frame_done against the reference.
  initial begin
    int seen_gen;
    logic prev_hold, prev_eof_acc;
    logic [DSIZE-1:0] prev_data, exp_d;
    logic [3:0] prev_flags;
    int pos, px, py;
    seen_gen = 0; prev_hold = 1'b0; prev_eof_acc = 1'b0;
    prev_data = '0; prev_flags = '0;
    forever begin
      @(negedge rclk);
      #4;
      if (seen_gen != reset_gen || !rrst_n) begin
        seen_gen = reset_gen;
        acc_cnt = 0;
        prev_hold = 1'b0;
        prev_eof_acc = 1'b0;
      end else begin
        chk("frame_done", frame_done, prev_eof_acc);
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_flags", {out_sol, out_eol, out_sof, out_eof}, prev_flags);
        end
        prev_eof_acc = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got data %0d, expected no output", out_data);
          end else begin
            exp_d = exp_q.pop_front();
            pos = acc_cnt % FRAME;
            px = pos % IMG_W;
            py = pos / IMG_W;
            chk("out_data", out_data, exp_d);
            chk("out_sol", out_sol, px == 0);
            chk("out_eol", out_eol, px == IMG_W - 1);
            chk("out_sof", out_sof, pos == 0);
            chk("out_eof", out_eof, pos == FRAME - 1);
            prev_eof_acc = (pos == FRAME - 1);
          end
          acc_cnt++;
          acc_tot++;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_flags = {out_sol, out_eol, out_sof, out_eof};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid, valid_cnt, fd_cnt, fd_step, acc_sum, pushed, n;

    // Reset state, with the FIFO already holding data and en high.
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DSIZE'(i));
    #2;
    chk("rst_rinc", rinc, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sol", out_sol, 1);
    chk("rst_out_sof", out_sof, 1);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (3) @(negedge rclk);
    rrst_n = 1'b1;

    // Streaming one 4x2 frame at full rate.
    first_valid = -1; valid_cnt = 0; fd_cnt = 0; fd_step = -1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (s == 0) chk("stream_first_rinc", rinc_s, 1);
      if (s_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = s;
      end
      if (s_fd) begin
        fd_cnt++;
        fd_step = s;
      end
    end
    chk("stream_latency", first_valid, 2);
    chk("stream_valid_cycles", valid_cnt, 8);
    chk("stream_frame_done_count", fd_cnt, 1);
    chk("stream_frame_done_cycle", fd_step, 10);

    // Empty boundary: one word, then an empty gap, then a refill.
    push_word(8'hA1);
    step();
    chk("empty_single_rinc", rinc_s, 1);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("empty_gap_rinc", rinc_s, 0);
    end
    for (int i = 2; i <= 4; i++) push_word(DSIZE'(8'hA0 + i));
    repeat (8) step();

    // Enable drop while backpressured.
    for (int i = 1; i <= 4; i++) push_word(DSIZE'(8'hB0 + i));
    out_ready = 1'b0;
    step();
    chk("drop_rinc_issued", rinc_s, 1);
    en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("drop_no_rinc", rinc_s, 0);
    end
    out_ready = 1'b1;
    acc_sum = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      chk("drop_no_rinc_drain", rinc_s, 0);
      acc_sum += int'(s_acc);
    end
    chk("drop_words_emerged", acc_sum, 1);
    drain();

    // Randomized backpressure over 1000 pixels.
    pushed = 0;
    n = 0;
    while (pushed < 1000 && n < 5000) begin
      while (fifo_q.size() < 3 && pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push_word(DSIZE'($urandom));
        pushed++;
      end
      out_ready = $urandom_range(0, 1) == 1;
      en = ($urandom_range(0, 7) != 0);
      step();
      n++;
    end
    chk("bp_all_pushed", pushed, 1000);
    drain();

    // Asynchronous reset mid-line with a full skid buffer.
    for (int i = 0; i < 12; i++) push_word(DSIZE'(8'hC0 + i));
    en = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while ((acc_cnt % IMG_W) != 2 && n < 40) begin
      step();
      n++;
    end
    chk("rst_mid_reach_x2", acc_cnt % IMG_W, 2);
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_mid_pre_valid", out_valid, 1);
    en = 1'b0;
    #1;
    rrst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_sof", out_sof, 1);
    chk("rst_mid_out_sol", out_sol, 1);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_rinc", rinc, 0);
    disc_tot = rd_tot - acc_tot;
    exp_q.delete();
    reset_gen++;
    rrst_n = 1'b1;
    @(negedge rclk);
    chk("post_rst_sof", out_sof, 1);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, meaning pixel data width; it SHALL match the upstream asyn_fifo DSIZE.
REQ-002 The block SHALL have parameter IMG_W, default 640, meaning pixels per line (>=2).
REQ-003 The block SHALL have parameter IMG_H, default 480, meaning lines per frame (>=2).
REQ-004 The block SHALL have port rclk, input, 1, the single clock; all logic is rising-edge on rclk.
REQ-005 The block SHALL have port rrst_n, input, 1, reset: asynchronous assert, active-low.
REQ-006 The block SHALL have port en, input, 1, read enable; when low, no new FIFO reads are issued.
REQ-007 The block SHALL have port rempty, input, 1, FIFO read-side empty flag.
REQ-008 The block SHALL have port rdata, input, DSIZE, FIFO read data; it is valid on the cycle after the rinc cycle.
REQ-009 The block SHALL have port rinc, output, 1, FIFO read strobe.
REQ-010 The block SHALL have port out_valid, output, 1, downstream data valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accept.
REQ-012 The block SHALL have port out_data, output, DSIZE, pixel data.
REQ-013 The block SHALL have ports out_sol, out_eol, out_sof and out_eof, output, 1 each: start/end of line and start/end of frame, qualified by out_valid.
REQ-014 The block SHALL have port frame_done, output, 1, a one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 Internal state SHALL be a 2-entry skid buffer (occ 0..2), an inflight flag (rinc delayed by one cycle), column counter x and row counter y, each $clog2 of its limit wide.
REQ-016 pop SHALL equal out_valid & out_ready; a transfer occurs only on that cycle.
REQ-017 rinc SHALL equal en & !rempty & ((occ + inflight - pop) < 2); it is combinational, with no registered delay.
REQ-018 When inflight is 1, the block SHALL write rdata into the skid tail that cycle; capture SHALL NOT be gated by en.
REQ-019 Simultaneous capture and pop SHALL leave occ unchanged, and ordering SHALL be strictly FIFO.
REQ-020 occ + inflight SHALL never exceed 2, and no captured word SHALL be dropped or duplicated.
REQ-021 out_valid SHALL equal (occ != 0), and out_data SHALL be the head entry.
REQ-022 Once out_valid is high, out_valid, out_data and the flags SHALL hold until pop.
REQ-023 Throughput: with rempty=0, en=1 and out_ready=1, the block SHALL sustain one pixel per cycle after a 2-cycle initial latency (rinc at cycle 0, capture at cycle 1, out_valid at cycle 2).
REQ-024 Flags SHALL be derived from the counters: out_sol=(x==0), out_eol=(x==IMG_W-1), out_sof=(x==0 && y==0), out_eof=(x==IMG_W-1 && y==IMG_H-1).
REQ-025 On pop, x SHALL increment; at IMG_W-1, x SHALL wrap to 0 and y SHALL increment; at IMG_H-1, y SHALL wrap to 0.
REQ-026 frame_done SHALL be registered, high exactly for the cycle after a pop with out_eof=1.
REQ-027 When en falls, the in-flight word SHALL still be captured and buffered words SHALL still drain; counters are unaffected by en.
REQ-028 When rempty is 1, rinc SHALL be 0 regardless of other inputs.

Reset
REQ-029 Asserting rrst_n=0 SHALL immediately (asynchronously) clear occ, inflight, x, y and frame_done; this forces rinc=0, out_valid=0, out_sol=1, out_sof=1, out_eol=0, out_eof=0.
REQ-030 Skid data contents need not be reset; out_data SHALL be 0 during reset.
REQ-031 Reset asserted mid-frame SHALL discard buffered and in-flight words; after reset the next pixel output SHALL carry out_sof=1.

Verification
REQ-032 Streaming test: IMG_W=4, IMG_H=2, FIFO preloaded with 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on consecutive cycles; out_sol at 0x01/0x05, out_eol at 0x04/0x08, out_sof at 0x01, out_eof at 0x08; frame_done pulses once, one cycle after 0x08.
REQ-033 Backpressure test: out_ready toggles 1,0,0,1 randomly over 1000 pixels -> output sequence identical to input; data is stable while valid&!ready; occ+inflight never exceeds 2.
REQ-034 Empty-boundary test: FIFO holds 1 word, then refills 5 cycles later -> a single rinc, then rinc=0 while rempty=1; no duplicate output.
REQ-035 Enable-drop test: en falls on the cycle rinc=1 with out_ready=0 -> that word is captured; no further rinc; after out_ready=1, exactly the buffered words emerge.
REQ-036 Reset test: rrst_n pulsed low mid-line (x=2, occ=2) without a clock edge -> out_valid drops immediately; the next frame starts with out_sof=1 at x=0.
